// File: rtl/programmable_ram_pkg.sv
// Shared types for the programmable main-memory block.
package programmable_ram_pkg;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_RUN   = 1'b1
  } ram_state_t;

endpackage

// File: rtl/programmable_ram_rising_edge_detect.sv
// Single-cycle pulse on the rising edge of a synchronised level (panel buttons).
module rising_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic in_q_r;

  // delayed copy of the input, updated every edge regardless of mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q_r <= 1'b0;
    end else begin
      in_q_r <= in;
    end
  end

  assign pulse = in & ~in_q_r;

endmodule

// File: rtl/programmable_ram.sv
// DATA_W x 2**ADDR_W main memory with post-reset zero fill, bus writes and
// front-panel programming (edge-triggered button, optional auto-increment pointer).
module programmable_ram
  import programmable_ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_from_bus,
  input  logic              manual_mode,
  input  logic              manual_write,
  input  logic              manual_auto_inc,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] program_switches,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              busy,
  output logic [ADDR_W-1:0] manual_address
);

  localparam int                DEPTH       = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam ram_state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_RUN;

  logic [DATA_W-1:0] mem_r [DEPTH];

  ram_state_t        state_r;
  ram_state_t        state_next_s;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic [ADDR_W-1:0] clr_ptr_next_s;
  logic [ADDR_W-1:0] man_ptr_r;
  logic [ADDR_W-1:0] man_ptr_next_s;
  logic [ADDR_W-1:0] eff_addr_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              wr_en_s;
  logic              btn_pulse_s;

  rising_edge_detect u_btn_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (manual_write),
    .pulse (btn_pulse_s)
  );

  // address used for panel reads/writes
  always_comb begin
    if (manual_mode && manual_auto_inc) begin
      eff_addr_s = man_ptr_r;
    end else begin
      eff_addr_s = address;
    end
  end

  // next-state, pointer updates and single write-port selection
  always_comb begin
    state_next_s   = state_r;
    clr_ptr_next_s = clr_ptr_r;
    wr_en_s        = 1'b0;
    wr_addr_s      = eff_addr_s;
    wr_data_s      = '0;
    // without auto-increment the pointer shadows the switches, so it is seeded on entry
    if (manual_auto_inc) begin
      man_ptr_next_s = man_ptr_r;
    end else begin
      man_ptr_next_s = address;
    end
    case (state_r)
      RAM_CLEAR: begin
        wr_en_s        = 1'b1;
        wr_addr_s      = clr_ptr_r;
        wr_data_s      = '0;
        clr_ptr_next_s = clr_ptr_r + 1'b1;
        if (clr_ptr_r == LAST_ADDR) begin
          state_next_s = RAM_RUN;
        end else begin
          state_next_s = RAM_CLEAR;
        end
      end
      RAM_RUN: begin
        if (!manual_mode) begin
          wr_en_s   = read_from_bus;
          wr_addr_s = address;
          wr_data_s = bus_in;
        end else if (btn_pulse_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = eff_addr_s;
          wr_data_s = program_switches;
          if (manual_auto_inc) begin
            man_ptr_next_s = man_ptr_r + 1'b1;
          end else begin
            man_ptr_next_s = address;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_next_s = RESET_STATE;
      end
    endcase
  end

  // control state; the memory array itself is deliberately not reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RESET_STATE;
      clr_ptr_r <= '0;
      man_ptr_r <= '0;
    end else begin
      state_r   <= state_next_s;
      clr_ptr_r <= clr_ptr_next_s;
      man_ptr_r <= man_ptr_next_s;
    end
  end

  // single write port
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  assign bus_out        = (state_r == RAM_RUN) ? mem_r[eff_addr_s] : '0;
  assign busy           = (state_r == RAM_CLEAR);
  assign manual_address = man_ptr_r;

endmodule

// File: tb/tb_programmable_ram.sv
// Directed self-checking bench for programmable_ram (default 8x16 configuration).
module tb_programmable_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       read_from_bus;
  logic       manual_mode;
  logic       manual_write;
  logic       manual_auto_inc;
  logic [3:0] address;
  logic [7:0] program_switches;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       busy;
  logic [3:0] manual_address;

  int n_checks = 0;
  int n_fail   = 0;

  programmable_ram #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RESET(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .read_from_bus    (read_from_bus),
    .manual_mode      (manual_mode),
    .manual_write     (manual_write),
    .manual_auto_inc  (manual_auto_inc),
    .address          (address),
    .program_switches (program_switches),
    .bus_in           (bus_in),
    .bus_out          (bus_out),
    .busy             (busy),
    .manual_address   (manual_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // read a word through bus_out using the external address
  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    address = a;
    #1;
    chk(tag, {24'd0, bus_out}, {24'd0, exp});
  endtask

  initial begin
    rst_n            = 1'b0;
    read_from_bus    = 1'b0;
    manual_mode      = 1'b0;
    manual_write     = 1'b0;
    manual_auto_inc  = 1'b0;
    address          = 4'h0;
    program_switches = 8'h00;
    bus_in           = 8'h00;
    #12;
    // 1: reset values, 16-edge fill, all words zero
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_bus_out", {24'd0, bus_out}, 32'd0);
    chk("rst_man_addr", {28'd0, manual_address}, 32'd0);
    rst_n = 1'b1;
    step(15);
    chk("fill_busy_15", {31'd0, busy}, 32'd1);
    step(1);
    chk("fill_busy_16", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "fill_zero");

    // 2: bus write
    @(negedge clk);
    address = 4'h3; bus_in = 8'hA5; read_from_bus = 1'b1;
    step(1);
    read_from_bus = 1'b0;
    #1;
    chk("bus_wr_3", {24'd0, bus_out}, 32'h0000_00A5);
    rd(4'h2, 8'h00, "bus_wr_2");
    rd(4'h4, 8'h00, "bus_wr_4");

    // 3: manual auto-increment from seed 0xE, wrapping
    @(negedge clk);
    manual_mode = 1'b1; manual_auto_inc = 1'b0; address = 4'hE;
    step(1);
    chk("seed_ptr", {28'd0, manual_address}, 32'hE);
    manual_auto_inc = 1'b1;
    program_switches = 8'h11; manual_write = 1'b1; step(1); manual_write = 1'b0; step(1);
    program_switches = 8'h22; manual_write = 1'b1; step(1); manual_write = 1'b0; step(1);
    program_switches = 8'h33; manual_write = 1'b1; step(1); manual_write = 1'b0; step(1);
    chk("auto_ptr_wrap", {28'd0, manual_address}, 32'h1);
    manual_mode = 1'b0;
    rd(4'hE, 8'h11, "man_wr_E");
    rd(4'hF, 8'h22, "man_wr_F");
    rd(4'h0, 8'h33, "man_wr_0");
    chk("ptr_retained", {28'd0, manual_address}, 32'h1);

    // 4: held button gives one write
    @(negedge clk);
    manual_mode = 1'b1; program_switches = 8'h5A; manual_write = 1'b1;
    step(1);
    program_switches = 8'h77;
    step(9);
    manual_write = 1'b0;
    step(1);
    chk("held_ptr", {28'd0, manual_address}, 32'h2);
    manual_mode = 1'b0;
    rd(4'h1, 8'h5A, "held_word1");
    rd(4'h2, 8'h00, "held_word2");

    // 5: bus write ignored in manual mode; reset mid-fill restarts the fill
    @(negedge clk);
    manual_mode = 1'b1; manual_auto_inc = 1'b0; address = 4'h5;
    bus_in = 8'hFF; read_from_bus = 1'b1;
    step(2);
    #1;
    chk("man_no_bus_wr", {24'd0, bus_out}, 32'd0);
    read_from_bus = 1'b0; manual_mode = 1'b0; manual_auto_inc = 1'b1;
    address = 4'h3;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step(7);
    chk("fill_bus_out_forced0", {24'd0, bus_out}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midfill_rst_busy", {31'd0, busy}, 32'd1);
    chk("midfill_rst_ptr", {28'd0, manual_address}, 32'd0);
    address = 4'h3; bus_in = 8'hC3; read_from_bus = 1'b1;
    rst_n = 1'b1;
    step(15);
    chk("refill_busy_15", {31'd0, busy}, 32'd1);
    step(1);
    chk("refill_busy_16", {31'd0, busy}, 32'd0);
    read_from_bus = 1'b0;
    rd(4'h3, 8'h00, "refill_word3");
    rd(4'hE, 8'h00, "refill_wordE");
    rd(4'hF, 8'h00, "refill_wordF");

    // 6: button held across reset release and fill never writes
    @(negedge clk);
    manual_mode = 1'b1; manual_auto_inc = 1'b1;
    program_switches = 8'h99; manual_write = 1'b1;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step(16);
    chk("held_rst_busy", {31'd0, busy}, 32'd0);
    step(3);
    chk("held_rst_ptr", {28'd0, manual_address}, 32'd0);
    chk("held_rst_word0", {24'd0, bus_out}, 32'd0);
    manual_write = 1'b0;
    step(1);
    manual_write = 1'b1;
    step(1);
    chk("press_ptr", {28'd0, manual_address}, 32'd1);
    manual_write = 1'b0;
    manual_mode = 1'b0;
    rd(4'h0, 8'h99, "press_word0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
